// File: rtl/tcore_param.sv
// ---------------------------------------------------------------------------
// tcore_param
//   Shared core parameters and types for the multiply/divide sequencer.
//   - XLEN           : default datapath width
//   - muldiv_op_e    : 3-bit M-extension operation code
//   - muldiv_state_e : sequencer FSM states
//   - op_is_div / op_signed_a / op_signed_b : opcode classification helpers
// ---------------------------------------------------------------------------
package tcore_param;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } muldiv_state_e;

  // Operation is served by the divider unit
  function automatic logic op_is_div(input muldiv_op_e op);
    case (op)
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // rs1 is interpreted as a signed value
  function automatic logic op_signed_a(input muldiv_op_e op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  // rs2 is interpreted as a signed value
  function automatic logic op_signed_b(input muldiv_op_e op);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_seq_fixup.sv
// ---------------------------------------------------------------------------
// muldiv_fixup
//   Combinational sign fixup for results coming back from the unsigned
//   multiplier/divider units, plus selection of the returned slice.
//   Ports:
//     op     : operation being completed
//     neg    : result must be two's-complement negated
//     prod   : unsigned 2*XLEN product from the multiplier
//     quo    : unsigned quotient from the divider
//     rem    : unsigned remainder from the divider
//     result : XLEN-bit architectural result
// ---------------------------------------------------------------------------
module muldiv_fixup
  import tcore_param::*;
#(
  parameter int unsigned XLEN = tcore_param::XLEN
) (
  input  muldiv_op_e        op,
  input  logic              neg,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;

  // Negate the full-width values first, then pick the slice the op returns
  always_comb begin
    if (neg) begin
      prod_fix_s = {(2*XLEN){1'b0}} - prod;
      quo_fix_s  = {XLEN{1'b0}} - quo;
      rem_fix_s  = {XLEN{1'b0}} - rem;
    end else begin
      prod_fix_s = prod;
      quo_fix_s  = quo;
      rem_fix_s  = rem;
    end
    case (op)
      OP_MUL:                       result = prod_fix_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo_fix_s;
      OP_REM, OP_REMU:              result = rem_fix_s;
      default:                      result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//   Sequencer that turns RISC-V M-extension requests into launches of
//   external unsigned multiplier/divider units and returns sign-fixed results.
//   Ports:
//     clk_i, rst_ni               : clock, async active-low reset
//     req_valid_i/req_ready_o     : request handshake (op_i, a_i, b_i)
//     flush_i                     : abort whatever is in flight
//     rsp_valid_o/rsp_ready_i     : response handshake (rsp_data_o)
//     busy_o                      : not idle, or a flushed unit still running
//     mul_start_o/div_start_o     : one-cycle unit launch pulses
//     mul_a_o/mul_b_o/div_a_o/div_b_o : unsigned operands to the units
//     mul_valid_i/mul_prod_i      : multiplier result strobe and product
//     div_valid_i/div_quo_i/div_rem_i : divider result strobe, quotient, remainder
// ---------------------------------------------------------------------------
module muldiv_seq
  import tcore_param::*;
#(
  parameter int unsigned XLEN = tcore_param::XLEN
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  muldiv_op_e        op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              flush_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              busy_o,
  output logic              mul_start_o,
  output logic              div_start_o,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  output logic [XLEN-1:0]   div_a_o,
  output logic [XLEN-1:0]   div_b_o,
  input  logic              mul_valid_i,
  input  logic              div_valid_i,
  input  logic [2*XLEN-1:0] mul_prod_i,
  input  logic [XLEN-1:0]   div_quo_i,
  input  logic [XLEN-1:0]   div_rem_i
);

  localparam logic [XLEN-1:0] ZERO_C    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_C    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG_C = {1'b1, {(XLEN-1){1'b0}}};

  // Registered state
  muldiv_state_e   state_r;
  muldiv_op_e      op_r;
  logic            neg_r;
  logic            use_div_r;
  logic [1:0]      drain_q;      // [0] multiplier, [1] divider result to discard
  logic            ready_r;
  logic            busy_r;
  logic            rsp_valid_r;
  logic [XLEN-1:0] rsp_data_r;
  logic            mul_start_r;
  logic            div_start_r;
  logic [XLEN-1:0] mul_a_r, mul_b_r, div_a_r, div_b_r;

  // Request decode
  logic            a_neg_s, b_neg_s, is_div_s, neg_res_s;
  logic [XLEN-1:0] a_opnd_s, b_opnd_s;
  logic            div_zero_s, ovf_s, bypass_s, accept_s;
  logic [XLEN-1:0] bypass_data_s;

  // Next-state view
  muldiv_state_e   state_n;
  logic [1:0]      drain_n;
  logic            unit_valid_s;
  logic [XLEN-1:0] fixup_s;

  // Decode the incoming request: sign flags, unit operands and bypass results
  always_comb begin
    is_div_s = op_is_div(op_i);
    a_neg_s  = op_signed_a(op_i) & a_i[XLEN-1];
    b_neg_s  = op_signed_b(op_i) & b_i[XLEN-1];
    if (a_neg_s) a_opnd_s = ZERO_C - a_i;
    else         a_opnd_s = a_i;
    if (b_neg_s) b_opnd_s = ZERO_C - b_i;
    else         b_opnd_s = b_i;
    case (op_i)
      OP_MUL, OP_MULH, OP_DIV: neg_res_s = a_neg_s ^ b_neg_s;
      OP_MULHSU, OP_REM:       neg_res_s = a_neg_s;
      default:                 neg_res_s = 1'b0;
    endcase
    // Divide by zero and signed overflow have fixed answers; the divider is skipped
    div_zero_s = is_div_s & (b_i == ZERO_C);
    ovf_s      = ((op_i == OP_DIV) | (op_i == OP_REM)) & (a_i == MIN_NEG_C) & (b_i == ONES_C);
    bypass_s   = div_zero_s | ovf_s;
    case (op_i)
      OP_DIV:  bypass_data_s = div_zero_s ? ONES_C : a_i;
      OP_DIVU: bypass_data_s = ONES_C;
      OP_REM:  bypass_data_s = div_zero_s ? a_i : ZERO_C;
      OP_REMU: bypass_data_s = a_i;
      default: bypass_data_s = ZERO_C;
    endcase
    accept_s = req_valid_i & ready_r & ~flush_i;
  end

  // Next state and drain tracking; flush has priority over every other event
  always_comb begin
    unit_valid_s = use_div_r ? div_valid_i : mul_valid_i;
    state_n      = state_r;
    drain_n      = drain_q & ~{div_valid_i, mul_valid_i};
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_n = bypass_s ? ST_DONE : ST_ISSUE;
        else          state_n = ST_IDLE;
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (unit_valid_s) state_n = ST_DONE;
        else              state_n = ST_WAIT;
      end
      ST_DONE: begin
        if (rsp_ready_i) state_n = ST_IDLE;
        else             state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (flush_i) begin
      state_n = ST_IDLE;
      // A launched unit will still answer; remember to swallow that answer.
      // If it answers in this very cycle there is nothing left to drain.
      if ((state_r == ST_ISSUE) || ((state_r == ST_WAIT) && !unit_valid_s)) begin
        drain_n = drain_n | (use_div_r ? 2'b10 : 2'b01);
      end else begin
        drain_n = drain_n;
      end
    end else begin
      state_n = state_n;
    end
  end

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .op     (op_r),
    .neg    (neg_r),
    .prod   (mul_prod_i),
    .quo    (div_quo_i),
    .rem    (div_rem_i),
    .result (fixup_s)
  );

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_MUL;
      neg_r       <= 1'b0;
      use_div_r   <= 1'b0;
      drain_q     <= 2'b00;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= ZERO_C;
      mul_start_r <= 1'b0;
      div_start_r <= 1'b0;
      mul_a_r     <= ZERO_C;
      mul_b_r     <= ZERO_C;
      div_a_r     <= ZERO_C;
      div_b_r     <= ZERO_C;
    end else begin
      state_r     <= state_n;
      drain_q     <= drain_n;
      ready_r     <= (state_n == ST_IDLE) && (drain_n == 2'b00);
      busy_r      <= !((state_n == ST_IDLE) && (drain_n == 2'b00));
      rsp_valid_r <= (state_n == ST_DONE);
      // Accept implies no drain pending, so a launch never overlaps a drain
      mul_start_r <= accept_s & ~bypass_s & ~is_div_s;
      div_start_r <= accept_s & ~bypass_s & is_div_s;
      if (accept_s) begin
        op_r      <= op_i;
        neg_r     <= neg_res_s;
        use_div_r <= is_div_s;
        if (is_div_s) begin
          div_a_r <= a_opnd_s;
          div_b_r <= b_opnd_s;
        end else begin
          mul_a_r <= a_opnd_s;
          mul_b_r <= b_opnd_s;
        end
        if (bypass_s) rsp_data_r <= bypass_data_s;
      end
      if ((state_r == ST_WAIT) && unit_valid_s && !flush_i) begin
        rsp_data_r <= fixup_s;
      end
    end
  end

  assign req_ready_o = ready_r;
  assign busy_o      = busy_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = rsp_data_r;
  assign mul_start_o = mul_start_r;
  assign div_start_o = div_start_r;
  assign mul_a_o     = mul_a_r;
  assign mul_b_o     = mul_b_r;
  assign div_a_o     = div_a_r;
  assign div_b_o     = div_b_r;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  sole clock
- rst_ni  in  1  reset, asynchronous and active-low
- req_valid_i  in  1  operation request
- req_ready_o  out  1  request accepted when high with req_valid_i
- op_i  in  3  muldiv_op_e: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- a_i, b_i  in  XLEN  rs1/rs2 operands
- flush_i  in  1  abort in-flight operation
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  result consumed
- rsp_data_o  out  XLEN  result
- busy_o  out  1  any state other than IDLE, or drain pending
- mul_start_o, div_start_o  out  1  one-cycle unit launch pulses
- mul_a_o, mul_b_o, div_a_o, div_b_o  out  XLEN  unsigned operands to units
- mul_valid_i, div_valid_i  in  1  unit result strobes
- mul_prod_i  in  2*XLEN  unsigned product
- div_quo_i, div_rem_i  in  XLEN  unsigned quotient and remainder

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-004 req_ready_o SHALL be high only in IDLE with no drain pending.
REQ-005 On accept, the block SHALL register op, the sign flags and the unit operands, then enter ISSUE.
- MULHSU: magnitude of a, raw b.
- MULHU, DIVU, REMU: raw a and b.
- MUL, MULH, DIV, REM: magnitudes of a and b.
REQ-006 In ISSUE, the block SHALL assert exactly one of mul_start_o or div_start_o for one cycle, then enter WAIT.
REQ-007 In WAIT, on the matching unit valid, the block SHALL register the sign-fixed result into rsp_data_o and enter DONE. The non-matching valid SHALL be ignored.
REQ-008 Sign fixup SHALL use two's-complement negation:
- MUL and MULH negate the 2*XLEN product if sign(a)^sign(b).
- MULHSU negates the product if sign(a).
- DIV negates the quotient if sign(a)^sign(b).
- REM negates the remainder if sign(a).
- MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
REQ-009 Divide by zero (b==0) SHALL bypass the divider and go from accept directly to DONE.
- DIV, DIVU: all-ones.
- REM, REMU: a.
REQ-010 Signed overflow (DIV or REM, a==2^(XLEN-1), b==all-ones) SHALL bypass the divider. Result: DIV returns a, REM returns 0.
REQ-011 In DONE, rsp_valid_o SHALL be high, and rsp_data_o SHALL hold stable until rsp_ready_i. On rsp_ready_i the block SHALL return to IDLE, and the next accept is possible in the following cycle.
REQ-012 Normal latency SHALL be: accept cycle, ISSUE, unit latency N, then rsp_valid_o in the cycle after the unit valid. Bypass latency SHALL be rsp_valid_o in the cycle after accept.
REQ-013 flush_i SHALL force IDLE next cycle from any state and deassert rsp_valid_o. flush_i SHALL override simultaneous req_valid_i, unit valid and rsp_ready_i.
REQ-014 A flush in ISSUE (start already pulsed) or WAIT SHALL set drain_q for the launched unit. drain_q SHALL clear on that unit's valid, and the discarded result SHALL not be output.
REQ-015 A start pulse SHALL never be issued while drain_q is set for either unit.
REQ-016 The block SHALL never assert mul_start_o and div_start_o in the same cycle.

Reset
REQ-017 Asserting rst_ni low SHALL immediately force IDLE and clear drain_q.
REQ-018 On reset, rsp_valid_o, mul_start_o, div_start_o and busy_o SHALL be 0, rsp_data_o and all operand outputs SHALL be 0, and req_ready_o SHALL be 1 after reset release.
REQ-019 Reset mid-operation SHALL discard the operation. Unit valids arriving after release SHALL be ignored in IDLE.

Structure
REQ-020 muldiv_op_e (3 bits) and the muldiv_state_e FSM enum SHALL be defined in tcore_param. XLEN SHALL come from tcore_param.
REQ-021 Sign fixup SHALL be one combinational sub-module, muldiv_fixup. The multiplier and divider units SHALL be instantiated outside this block.

Verification
REQ-022 The bench SHALL cover these directed scenarios, using unit models with latency 4:
- MUL a=-3, b=7 -> one mul_start_o pulse, operands 3/7, product 21 -> rsp 0xFFFFFFEB, rsp_valid_o at accept+6.
- MULHSU a=-1, b=0xFFFFFFFF -> rsp 0xFFFFFFFF.
- DIV a=-7, b=2 -> quotient -3 (0xFFFFFFFD). REM a=-7, b=2 -> 0xFFFFFFFF.
- DIVU a=5, b=0 -> no div_start_o, rsp 0xFFFFFFFF at accept+1. REM a=0x80000000, b=0xFFFFFFFF -> rsp 0.
- flush_i in WAIT of a DIVU -> IDLE next cycle, req_ready_o low until div_valid_i, stale result never on rsp_data_o, next DIVU 10/3 -> 3.
- rsp_ready_i held low 5 cycles -> rsp_valid_o and rsp_data_o stable. rst_ni low in WAIT -> all outputs 0 asynchronously.
